shift_rotate_unit: RTL and testbench
====================================

SHIFT_ROTATE_UNIT -- requirements
Module: shift_rotate_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width; power of two, >= 16.
REQ-002 Parameter STEP, default 1: max bit positions shifted per cycle; power of two, 1..WIDTH.
REQ-003 Parameter AMT_W, default 8: shift-amount width (unsigned).
REQ-004 One clock; reset is asynchronous and active-low: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-005 in_valid input 1: request present.
REQ-006 in_ready output 1: unit accepts request.
REQ-007 operand input WIDTH: value to shift.
REQ-008 amount input AMT_W: shift count, ignored when imm_mode=1.
REQ-009 mode input 2: 00 LSL, 01 LSR, 10 ASR, 11 ROR; ignored when imm_mode=1.
REQ-010 imm_mode input 1: decode operand[11:0] as rotated immediate.
REQ-011 carry_in input 1: carry flag, returned when no bit is shifted out.
REQ-012 flush input 1: synchronous abort of the operation in flight.
REQ-013 out_valid output 1: result available.
REQ-014 out_ready input 1: consumer takes result.
REQ-015 result output WIDTH: shifted value.
REQ-016 carry_out output 1: shifter carry.

Function
REQ-017 The FSM SHALL have states IDLE, SHIFT and DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 A request SHALL be accepted on a clk edge with in_valid=1 and in_ready=1, latching operand, effective count, mode and carry_in.
REQ-019 imm_mode=1 SHALL load value {zero-extended operand[7:0]}, mode ROR and count 2*operand[11:8].
REQ-020 Effective count: LSL/LSR/ASR SHALL use min(amount, WIDTH); ROR SHALL use amount mod WIDTH.
REQ-021 Effective count 0 SHALL go IDLE->DONE, giving result=operand and carry_out=carry_in, except ROR with amount a nonzero multiple of WIDTH, which SHALL give carry_out=operand[WIDTH-1].
REQ-022 In SHIFT, each cycle SHALL shift by min(STEP, remaining) and decrement remaining; when remaining reaches 0 the FSM SHALL enter DONE; the accept-to-out_valid latency SHALL be ceil(count/STEP)+1 cycles.
REQ-023 LSL and LSR SHALL fill with 0, ASR SHALL fill with operand[WIDTH-1], and ROR SHALL feed back the bits shifted out.
REQ-024 carry_out SHALL be the last bit shifted out, except that LSL/LSR with amount > WIDTH SHALL give carry_out 0.
REQ-025 ASR with amount >= WIDTH SHALL give all result bits and carry_out equal to operand[WIDTH-1].
REQ-026 In DONE, result and carry_out SHALL hold stable until out_ready=1; the FSM SHALL then return to IDLE on that edge.
REQ-027 flush=1 in SHIFT or DONE SHALL force IDLE on the next edge with no out_valid; flush SHALL take priority over every other transition; flush in IDLE SHALL be ignored.
REQ-028 A new request SHALL NOT be accepted in the same cycle a result is consumed.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, result=0, carry_out=0, out_valid=0 and remaining=0, including mid-SHIFT.
REQ-030 After rst_n deasserts, in_ready SHALL be 1 from the first clk edge.

Configuration
REQ-031 Macro SHIFT_ROTATE_CARRY_EN defined: carry_out SHALL behave per REQ-021, REQ-024 and REQ-025.
REQ-032 Macro SHIFT_ROTATE_CARRY_EN undefined: carry_out SHALL be constant 0, carry_in SHALL be ignored, and no carry register SHALL exist; result timing SHALL be unchanged.

Verification (WIDTH=32, STEP=1, macro defined unless stated)
REQ-033 imm_mode=1, operand[11:0]=0x4FF, carry_in=0 -> result 0xFF000000, carry_out 1, out_valid 9 cycles after accept.
REQ-034 LSL, operand 0x80000001, amount 1 -> result 0x00000002, carry_out 1; LSR, amount 33 -> result 0, carry_out 0.
REQ-035 ASR, operand 0x80000000, amount 40 -> result 0xFFFFFFFF, carry_out 1, 32 SHIFT cycles; repeat with STEP=8 -> 4 SHIFT cycles.
REQ-036 ROR, amount 0, carry_in 1, operand 0x12345678 -> result 0x12345678, carry_out 1, out_valid 1 cycle after accept; ROR, amount 32 -> same result, carry_out 0.
REQ-037 out_ready held 0 for 3 cycles in DONE -> result stable, in_ready 0; flush at SHIFT cycle 2 -> IDLE next edge, out_valid never 1.
REQ-038 rst_n pulsed low mid-SHIFT -> outputs 0 asynchronously, in_ready 1 after release; macro undefined -> carry_out 0 in all of the above.

Source files
------------

// File: rtl/shift_rotate_unit.sv
// shift_rotate_unit: multi-cycle barrel-less shifter/rotator (LSL, LSR, ASR, ROR,
// rotated immediate) that moves up to STEP bit positions per clock.
// Optional feature macro: SHIFT_ROTATE_CARRY_EN enables the carry_out flag path;
// without it carry_out is tied to 0 and carry_in is ignored.
module shift_rotate_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1,
    parameter int unsigned AMT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand,
    input  logic [AMT_W-1:0] amount,
    input  logic [1:0]       mode,
    input  logic             imm_mode,
    input  logic             carry_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned CMP_W = (AMT_W > CNT_W) ? AMT_W : CNT_W;
    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] STEP_C  = CNT_W'(STEP);

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             shift_en;

    logic [CNT_W-1:0] remaining_q;
    logic [1:0]       mode_q;

    logic [CMP_W-1:0] amt_x;
    logic             amt_over;
    logic [CNT_W-1:0] ror_cnt;
    logic [WIDTH-1:0] ld_value;
    logic [1:0]       ld_mode;
    logic [CNT_W-1:0] ld_count;

    logic [CNT_W-1:0] step_n;
    logic [WIDTH:0]   lsl_w;
    logic [WIDTH:0]   rsh_w;
    logic [WIDTH:0]   asr_w;
    logic [WIDTH-1:0] ror_v;
    logic [WIDTH-1:0] step_value;

    // Request decode: effective value, mode and count loaded on accept
    always_comb begin
        amt_x    = CMP_W'(amount);
        amt_over = amt_x > CMP_W'(WIDTH);
        ror_cnt  = CNT_W'(amt_x & CMP_W'(WIDTH - 1));
        ld_value = operand;
        ld_mode  = mode;
        ld_count = amt_over ? WIDTH_C : CNT_W'(amt_x);
        if (imm_mode) begin
            ld_value = WIDTH'(operand[7:0]);
            ld_mode  = MODE_ROR;
            ld_count = CNT_W'({operand[11:8], 1'b0});
        end else if (mode == MODE_ROR) begin
            ld_count = ror_cnt;
        end
    end

    // One shift step of min(STEP, remaining); extended vectors capture the bit shifted out
    always_comb begin
        step_n = (remaining_q > STEP_C) ? STEP_C : remaining_q;
        lsl_w  = {1'b0, result} << step_n;
        rsh_w  = {result, 1'b0} >> step_n;
        asr_w  = $signed({result, 1'b0}) >>> step_n;
        ror_v  = (result >> step_n) | (result << (WIDTH_C - step_n));
        case (mode_q)
            MODE_LSL: step_value = lsl_w[WIDTH-1:0];
            MODE_LSR: step_value = rsh_w[WIDTH:1];
            MODE_ASR: step_value = asr_w[WIDTH:1];
            default:  step_value = ror_v;
        endcase
    end

    // Next-state logic; flush overrides everything outside IDLE
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept  = 1'b1;
                    state_d = (ld_count == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    shift_en = 1'b1;
                    if (remaining_q <= STEP_C) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (flush || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and handshake outputs, registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
        end
    end

    // Working value doubles as the result register; holds in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result      <= '0;
            remaining_q <= '0;
            mode_q      <= MODE_LSL;
        end else if (accept) begin
            result      <= ld_value;
            remaining_q <= ld_count;
            mode_q      <= ld_mode;
        end else if (shift_en) begin
            result      <= step_value;
            remaining_q <= remaining_q - step_n;
        end
    end

`ifdef SHIFT_ROTATE_CARRY_EN
    logic carry_q;
    logic kill_q;
    logic ld_wrap;
    logic ld_kill;
    logic step_carry;

    // ROR by a nonzero multiple of WIDTH reports the MSB; over-long logical shifts force carry 0
    always_comb begin
        ld_wrap = !imm_mode && (mode == MODE_ROR) && (amt_x != '0) && (ror_cnt == '0);
        ld_kill = !imm_mode && ((mode == MODE_LSL) || (mode == MODE_LSR)) && amt_over;
        case (mode_q)
            MODE_LSL: step_carry = lsl_w[WIDTH];
            MODE_LSR: step_carry = rsh_w[0];
            MODE_ASR: step_carry = asr_w[0];
            default:  step_carry = ror_v[WIDTH-1];
        endcase
    end

    // Carry flag: seeded on accept, replaced by the last bit out on every step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            kill_q  <= 1'b0;
        end else if (accept) begin
            carry_q <= ld_wrap ? operand[WIDTH-1] : carry_in;
            kill_q  <= ld_kill;
        end else if (shift_en) begin
            carry_q <= kill_q ? 1'b0 : step_carry;
        end
    end

    assign carry_out = carry_q;
`else
    logic       unused_carry_in;
    logic [2:0] unused_step_bits;

    assign unused_carry_in  = carry_in;
    assign unused_step_bits = {lsl_w[WIDTH], rsh_w[0], asr_w[0]};
    assign carry_out        = 1'b0;
`endif

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Self-checking bench for shift_rotate_unit: scoreboard on a STEP=1 instance,
// directed latency checks on a STEP=8 instance.
module tb_shift_rotate_unit;

    localparam logic [1:0] M_LSL = 2'b00;
    localparam logic [1:0] M_LSR = 2'b01;
    localparam logic [1:0] M_ASR = 2'b10;
    localparam logic [1:0] M_ROR = 2'b11;

    typedef struct {
        logic [31:0] result;
        logic        carry;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] operand = '0;
    logic [7:0]  amount = '0;
    logic [1:0]  mode = '0;
    logic        imm_mode = 1'b0;
    logic        carry_in = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        carry_out;

    logic        s8_in_valid = 1'b0;
    logic        s8_in_ready;
    logic [31:0] s8_operand = '0;
    logic [7:0]  s8_amount = '0;
    logic [1:0]  s8_mode = '0;
    logic        s8_out_valid;
    logic [31:0] s8_result;
    logic        s8_carry_out;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   first_cyc = 0;
    logic seen_valid = 1'b0;
    exp_t sb_q[$];

    shift_rotate_unit #(.WIDTH(32), .STEP(1), .AMT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .operand(operand), .amount(amount), .mode(mode), .imm_mode(imm_mode),
        .carry_in(carry_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out)
    );

    shift_rotate_unit #(.WIDTH(32), .STEP(8), .AMT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(s8_in_valid), .in_ready(s8_in_ready),
        .operand(s8_operand), .amount(s8_amount), .mode(s8_mode), .imm_mode(1'b0),
        .carry_in(1'b0), .flush(1'b0), .out_valid(s8_out_valid), .out_ready(1'b1),
        .result(s8_result), .carry_out(s8_carry_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model written from the architectural definition of each operation
    function automatic exp_t model(input logic [31:0] op, input int unsigned amt, input logic [1:0] md_in,
                                   input logic imm, input logic cin, input int unsigned step);
        exp_t        e;
        logic [31:0] v;
        logic [31:0] t;
        logic [1:0]  md;
        int unsigned a;
        int unsigned cnt;
        v  = op;
        a  = amt;
        md = md_in;
        if (imm) begin
            v  = {24'h0, op[7:0]};
            md = M_ROR;
            a  = 32'(op[11:8]) * 2;
        end
        e.result = v;
        e.carry  = cin;
        cnt      = (a > 32) ? 32 : a;
        case (md)
            M_LSL: begin
                if (a >= 1 && a <= 31) begin
                    e.result = v << a;
                    t = v >> (32 - a);
                    e.carry = t[0];
                end else if (a == 32) begin
                    e.result = '0;
                    e.carry  = v[0];
                end else if (a > 32) begin
                    e.result = '0;
                    e.carry  = 1'b0;
                end
            end
            M_LSR: begin
                if (a >= 1 && a <= 31) begin
                    e.result = v >> a;
                    t = v >> (a - 1);
                    e.carry = t[0];
                end else if (a == 32) begin
                    e.result = '0;
                    e.carry  = v[31];
                end else if (a > 32) begin
                    e.result = '0;
                    e.carry  = 1'b0;
                end
            end
            M_ASR: begin
                if (a >= 1 && a <= 31) begin
                    e.result = $signed(v) >>> a;
                    t = v >> (a - 1);
                    e.carry = t[0];
                end else if (a >= 32) begin
                    e.result = {32{v[31]}};
                    e.carry  = v[31];
                end
            end
            default: begin
                cnt = a % 32;
                if (cnt != 0) begin
                    e.result = (v >> cnt) | (v << (32 - cnt));
                    e.carry  = e.result[31];
                end else if (a != 0) begin
                    e.carry = v[31];
                end
            end
        endcase
`ifndef SHIFT_ROTATE_CARRY_EN
        e.carry = 1'b0;
`endif
        e.lat = int'((cnt + step - 1) / step) + 1;
        return e;
    endfunction

    // Scoreboard monitor: tracks accept/first-valid cycles, compares on consumption
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) acc_cyc = cyc + 1;
            if (out_valid) begin
                if (!seen_valid) begin
                    first_cyc  = cyc;
                    seen_valid = 1'b1;
                end
                check_eq("in_ready_in_done", 64'(in_ready), 64'd0);
                if (sb_q.size() == 0) begin
                    check_eq("spurious_valid", 64'(out_valid), 64'd0);
                end else begin
                    check_eq(out_ready ? "result" : "result_hold", 64'(result), 64'(sb_q[0].result));
                    check_eq(out_ready ? "carry" : "carry_hold", 64'(carry_out), 64'(sb_q[0].carry));
                    if (out_ready) begin
                        check_eq("latency", 64'(first_cyc - acc_cyc + 1), 64'(sb_q[0].lat));
                        void'(sb_q.pop_front());
                        seen_valid = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_ready();
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic drive(input logic [31:0] op, input logic [7:0] amt, input logic [1:0] md,
                         input logic imm, input logic cin);
        operand  = op;
        amount   = amt;
        mode     = md;
        imm_mode = imm;
        carry_in = cin;
        in_valid = 1'b1;
    endtask

    task automatic run_op(input logic [31:0] op, input logic [7:0] amt, input logic [1:0] md,
                          input logic imm, input logic cin, input int hold);
        int guard = 0;
        wait_ready();
        out_ready = (hold == 0);
        drive(op, amt, md, imm, cin);
        sb_q.push_back(model(op, 32'(amt), md, imm, cin, 1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!out_valid) begin
            check_eq("valid_timeout", 64'(out_valid), 64'd1);
            sb_q.delete();
            out_ready = 1'b1;
            return;
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_op8(input logic [31:0] op, input logic [7:0] amt, input logic [1:0] md);
        exp_t e;
        int   n = 0;
        while (!s8_in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        e = model(op, 32'(amt), md, 1'b0, 1'b0, 8);
        s8_operand  = op;
        s8_amount   = amt;
        s8_mode     = md;
        s8_in_valid = 1'b1;
        @(posedge clk); #1;
        s8_in_valid = 1'b0;
        n = 1;
        while (!s8_out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("s8_latency", 64'(n), 64'(e.lat));
        check_eq("s8_result", 64'(s8_result), 64'(e.result));
        check_eq("s8_carry", 64'(s8_carry_out), 64'(e.carry));
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int vcount;

        // Reset state
        #1;
        check_eq("rst_result", 64'(result), 64'd0);
        check_eq("rst_carry", 64'(carry_out), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("ready_after_rst", 64'(in_ready), 64'd1);

        // Directed operations
        run_op(32'h0000_04FF, 8'd0, M_LSL, 1'b1, 1'b0, 0);
        run_op(32'h0000_00A5, 8'd0, M_LSL, 1'b1, 1'b1, 0);
        run_op(32'h8000_0001, 8'd1, M_LSL, 1'b0, 1'b0, 0);
        run_op(32'h8000_0001, 8'd33, M_LSR, 1'b0, 1'b1, 0);
        run_op(32'h8000_0001, 8'd32, M_LSL, 1'b0, 1'b0, 0);
        run_op(32'h8000_0000, 8'd32, M_LSR, 1'b0, 1'b0, 0);
        run_op(32'h8000_0001, 8'd200, M_LSL, 1'b0, 1'b1, 0);
        run_op(32'h8000_0000, 8'd40, M_ASR, 1'b0, 1'b0, 0);
        run_op(32'h4000_0000, 8'd3, M_ASR, 1'b0, 1'b1, 0);
        run_op(32'hF000_000C, 8'd3, M_ASR, 1'b0, 1'b0, 0);
        run_op(32'h1234_5678, 8'd0, M_ROR, 1'b0, 1'b1, 0);
        run_op(32'h1234_5678, 8'd32, M_ROR, 1'b0, 1'b1, 0);
        run_op(32'h8000_0001, 8'd64, M_ROR, 1'b0, 1'b0, 0);
        run_op(32'h1234_5678, 8'd36, M_ROR, 1'b0, 1'b0, 0);
        run_op(32'h0F0F_0F0F, 8'd0, M_LSL, 1'b0, 1'b1, 0);

        // Result held while consumer stalls
        run_op(32'hDEAD_BEEF, 8'd5, M_LSR, 1'b0, 1'b0, 3);

        // Flush in SHIFT: no out_valid, back to IDLE
        wait_ready();
        drive(32'hCAFE_F00D, 8'd10, M_ROR, 1'b0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_eq("flush_shift_ready", 64'(in_ready), 64'd1);
        vcount = 0;
        repeat (15) begin
            if (out_valid) vcount++;
            @(posedge clk); #1;
        end
        check_eq("flush_shift_no_valid", 64'(vcount), 64'd0);

        // Flush in DONE while stalled
        wait_ready();
        out_ready = 1'b0;
        drive(32'h0000_1111, 8'd0, M_LSR, 1'b0, 1'b1);
        sb_q.push_back(model(32'h0000_1111, 0, M_LSR, 1'b0, 1'b1, 1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("stall_valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_eq("flush_done_valid", 64'(out_valid), 64'd0);
        check_eq("flush_done_ready", 64'(in_ready), 64'd1);
        void'(sb_q.pop_front());
        seen_valid = 1'b0;
        out_ready  = 1'b1;

        // Randomised operations
        for (int i = 0; i < 24; i++) begin
            run_op($urandom, 8'($urandom_range(0, 70)), 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0) ? 2 : 0);
        end

        // STEP=8 instance
        run_op8(32'h8000_0000, 8'd40, M_ASR);
        run_op8(32'h0008_0001, 8'd13, M_LSL);
        run_op8(32'h1234_5678, 8'd0, M_ROR);

        // Asynchronous reset mid-SHIFT
        wait_ready();
        drive(32'h8000_0000, 8'd30, M_ASR, 1'b0, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst_result", 64'(result), 64'd0);
        check_eq("arst_carry", 64'(carry_out), 64'd0);
        check_eq("arst_out_valid", 64'(out_valid), 64'd0);
        check_eq("arst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("arst_ready_after", 64'(in_ready), 64'd1);
        run_op(32'h0000_0003, 8'd2, M_LSL, 1'b0, 1'b0, 0);

        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
